// File: rtl/alu64_registered.sv
// 64-bit execute-stage ALU: ripple add/sub chain, per-bit 8:1 result select,
// and registered result/flags with one cycle of latency.

module fullAdderSubtractor (
    input  logic a,
    input  logic b,
    input  logic sub,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic bx;
    assign bx   = b ^ sub;
    assign sum  = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

module mux8_1 (
    input  logic [2:0] sel,
    input  logic [7:0] d,
    output logic       y
);
    assign y = d[sel];
endmodule

module nor_64 (
    input  logic [63:0] d,
    output logic        y
);
    assign y = ~|d;
endmodule

module alu64_registered (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [2:0]  cntrl,
    output logic [63:0] result,
    output logic        negative,
    output logic        zero,
    output logic        overflow,
    output logic        carry_out
);
    logic [64:0] c;
    logic [63:0] s;
    logic [63:0] res_d;
    logic        zero_d;

    assign c[0] = cntrl[0];

    for (genvar i = 0; i < 64; i++) begin : g_bit
        fullAdderSubtractor u_fas (
            .a   (A[i]),
            .b   (B[i]),
            .sub (cntrl[0]),
            .cin (c[i]),
            .sum (s[i]),
            .cout(c[i+1])
        );

        // Slots 2 and 3 share the chain; cntrl[0] already selects add vs sub.
        mux8_1 u_mux (
            .sel(cntrl),
            .d  ({1'b0, A[i] ^ B[i], A[i] | B[i], A[i] & B[i],
                  s[i], s[i], 1'b0, B[i]}),
            .y  (res_d[i])
        );
    end

    nor_64 u_zero (
        .d(res_d),
        .y(zero_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else if (en) begin
            result    <= res_d;
            negative  <= res_d[63];
            zero      <= zero_d;
            overflow  <= c[64] ^ c[63];
            carry_out <= c[64];
        end
    end
endmodule

// File: tb/tb_alu64_registered.sv
// Directed-vector bench for alu64_registered with hand-computed expectations.

module tb_alu64_registered;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int total = 0;
    int bad   = 0;

    alu64_registered dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .A        (A),
        .B        (B),
        .cntrl    (cntrl),
        .result   (result),
        .negative (negative),
        .zero     (zero),
        .overflow (overflow),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] r,
                           input logic n, input logic z,
                           input logic v, input logic c);
        chk({tag, ".result"}, result, r);
        chk({tag, ".neg"}, {63'd0, negative}, {63'd0, n});
        chk({tag, ".zero"}, {63'd0, zero}, {63'd0, z});
        chk({tag, ".ovf"}, {63'd0, overflow}, {63'd0, v});
        chk({tag, ".cout"}, {63'd0, carry_out}, {63'd0, c});
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op);
        A = a;
        B = b;
        cntrl = op;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] LA = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] LB = 64'hFF00_FF00_FF00_FF00;

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        drive('1, '1, 3'b010);
        chk_all("reset", 64'd0, 0, 1, 0, 0);

        reset = 1'b0;
        drive('1, '1, 3'b010);
        chk_all("add_ones", 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 1);

        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        chk_all("add_ovf", 64'h8000_0000_0000_0000, 1, 0, 1, 0);

        drive(64'd5, 64'd3, 3'b011);
        chk_all("sub_5_3", 64'd2, 0, 0, 0, 1);
        drive(64'd0, 64'd1, 3'b011);
        chk_all("sub_0_1", '1, 1, 0, 0, 0);
        drive(64'h1234, 64'h1234, 3'b011);
        chk_all("sub_eq", 64'd0, 0, 1, 0, 1);

        drive(LA, LB, 3'b100);
        chk_all("and", 64'hF000_F000_F000_F000, 1, 0, 0, 1);
        drive(LA, LB, 3'b101);
        chk_all("or", 64'hFFF0_FFF0_FFF0_FFF0, 1, 0, 0, 0);
        drive(LA, LB, 3'b110);
        chk_all("xor", 64'h0FF0_0FF0_0FF0_0FF0, 0, 0, 0, 1);

        drive(64'd0, 64'h8000_0000_0000_0001, 3'b000);
        chk_all("pass_b", 64'h8000_0000_0000_0001, 1, 0, 0, 0);
        drive(64'd0, 64'h8000_0000_0000_0001, 3'b001);
        chk_all("op001", 64'd0, 0, 1, 0, 0);
        drive(64'd0, 64'h8000_0000_0000_0001, 3'b111);
        chk_all("op111", 64'd0, 0, 1, 0, 0);

        drive(64'd5, 64'd3, 3'b011);
        chk_all("load2", 64'd2, 0, 0, 0, 1);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(64'd9, 64'd9, 3'b010);
            chk_all($sformatf("hold%0d", k), 64'd2, 0, 0, 0, 1);
        end
        en = 1'b1;
        drive(64'd9, 64'd9, 3'b010);
        chk_all("resume", 64'd18, 0, 0, 0, 0);

        reset = 1'b1;
        en    = 1'b0;
        drive('1, '1, 3'b010);
        chk_all("reset_mid", 64'd0, 0, 1, 0, 0);
        reset = 1'b0;
        en    = 1'b1;
        drive(64'd5, 64'd3, 3'b011);
        chk_all("after_rst", 64'd2, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu64_registered.md
Name: alu64_registered

Overview:
- 64-bit integer ALU with registered result and status flags.
- Datapath is built from the team's existing primitives:
  - 64 ripple-chained fullAdderSubtractor bit cells.
  - One mux8_1 per result bit, selected by the opcode.
  - One nor_64 to produce the zero flag.
- Sits in the CPU execute stage. Operands and opcode are sampled on the rising clock edge; result and flags appear one cycle later.

Parameters:
- none (width fixed at 64; opcode fixed at 3 bits)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  capture enable; when low, all outputs hold their value
- A  input  64  operand A
- B  input  64  operand B
- cntrl  input  3  operation select
- result  output  64  registered operation result
- negative  output  1  registered copy of result bit 63
- zero  output  1  registered flag, 1 when the registered result is all zeros
- overflow  output  1  registered signed overflow of the add/sub chain
- carry_out  output  1  registered carry out of bit 63 of the add/sub chain

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising clk edge with reset=1, outputs become result=0, negative=0, zero=1, overflow=0, carry_out=0. Reset has priority over en.
- Latency: exactly 1 cycle. When en=1 and reset=0, the values computed from A, B and cntrl at the edge are registered and visible after that edge. When en=0, all outputs hold.
- Opcode decode (cntrl → result):
  - 000: B (pass-through)
  - 001: 0
  - 010: A+B
  - 011: A−B
  - 100: A AND B
  - 101: A OR B
  - 110: A XOR B
  - 111: 0
- Add/sub chain:
  - Bit cell i computes sum = A[i] XOR (B[i] XOR sub) XOR cin.
  - Carry out is the majority of A[i], (B[i] XOR sub) and cin.
  - sub = cntrl[0]; bit 0 cin = cntrl[0]. This gives two's-complement subtraction as A + ~B + 1.
  - Result wraps modulo 2^64.
- carry_out = carry out of bit 63. For subtraction, carry_out=1 means no borrow (A ≥ B unsigned).
- overflow = carry out of bit 63 XOR carry out of bit 62.
- Flags on non-arithmetic opcodes: the chain is always active with sub=cntrl[0]. For opcodes other than 010/011, overflow and carry_out still reflect that chain (not forced to 0). Verification must check them against the chain model.
- negative = result[63]; zero = NOR of all 64 result bits. Both are computed from the selected result (every opcode) before registering.
- Selection: per bit, an 8:1 mux indexed by cntrl picks among the eight candidate values above. Inputs 1 and 7 are tied to 0; no X may reach the outputs.
- Combinational path is purely ripple. No timing delays are modelled in the synthesizable RTL.
- Reset asserted mid-stream: the next edge clears outputs regardless of en or inputs. The first capture after reset deasserts follows normal rules.

Test Plan:
- Reset: drive reset=1 for one edge with A=B=all ones, cntrl=010, en=1 → result=0, zero=1, negative=0, overflow=0, carry_out=0. Deassert; next edge → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=1, negative=1, overflow=0.
- Add overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, cntrl=010 → after 1 edge result=0x8000_0000_0000_0000, negative=1, overflow=1, carry_out=0, zero=0.
- Subtract: A=5, B=3, cntrl=011 → result=2, carry_out=1, overflow=0. Then A=0, B=1, cntrl=011 → result=all ones, carry_out=0, negative=1. Then A=B=0x1234, cntrl=011 → result=0, zero=1, carry_out=1.
- Logic ops: A=0xF0F0_F0F0_F0F0_F0F0, B=0xFF00_FF00_FF00_FF00:
  - 100 → 0xF000_F000_F000_F000
  - 101 → 0xFFF0_FFF0_FFF0_FFF0
  - 110 → 0x0FF0_0FF0_0FF0_0FF0
  - Each also checks negative per bit 63 and carry/overflow per the chain model.
- Pass and unused codes: B=0x8000_0000_0000_0001, cntrl=000 → result=B, negative=1. cntrl=001 and cntrl=111 → result=0, zero=1.
- Enable hold: load result=2 via A=5, B=3, cntrl=011 (en=1). Then en=0 with new inputs (A=9, B=9, cntrl=010) for 3 edges → all outputs unchanged. Then en=1 → result=18.
